argon_sequencer: RTL and testbench



---
 rtl/argon_sequencer_if.sv | 29 ++
 rtl/argon_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_argon_sequencer.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/argon_sequencer_if.sv
// Memory request bus between the Argon sequencer (master) and the memory port (slave).
// Handshake: a transfer completes on the rising edge where mem_re or mem_we is high and
// mem_busy is low; mem_address and the strobe stay stable until that edge, mem_rdata is valid on it.
interface argon_sequencer_if #(
  parameter int XLEN = 16,
  parameter int ILEN = 32
) ();
  logic [XLEN-1:0] mem_address;
  logic            mem_re;
  logic            mem_we;
  logic            mem_busy;
  logic [ILEN-1:0] mem_rdata;

  modport master (
    output mem_address,
    output mem_re,
    output mem_we,
    input  mem_busy,
    input  mem_rdata
  );

  modport slave (
    input  mem_address,
    input  mem_re,
    input  mem_we,
    output mem_busy,
    output mem_rdata
  );
endinterface

// File: rtl/argon_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer for the Argon core: PC, IR, memory handshake, retire.
// Optional ARGON_SEQ_PERF_EN adds free-running cycle and retire counters.
module argon_sequencer #(
  parameter int              XLEN         = 16,
  parameter int              ILEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              PC_STEP      = 4,
  parameter int              TIMEOUT_W    = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_halt,
  argon_sequencer_if.master   mem,
  input  logic                i_dec_is_load,
  input  logic                i_dec_is_store,
  input  logic                i_dec_writes_rd,
  input  logic                i_branch_taken,
  input  logic [XLEN-1:0]     i_branch_target,
  input  logic [XLEN-1:0]     i_ex_address,
  output logic [XLEN-1:0]     o_pc,
  output logic [ILEN-1:0]     o_instruction,
  output logic [XLEN-1:0]     o_load_data,
  output logic [2:0]          o_stage,
  output logic                o_reg_write_en,
  output logic                o_retire,
  output logic                o_fault
`ifdef ARGON_SEQ_PERF_EN
  ,
  output logic [31:0]         o_cycle_count,
  output logic [31:0]         o_retire_count
`endif
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_FAULT = 3'd7
  } state_e;

  localparam logic [XLEN-1:0]      PC_INC    = XLEN'(PC_STEP);
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_e                state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [ILEN-1:0]       ir_q, ir_d;
  logic [XLEN-1:0]       load_data_q, load_data_d;
  logic                  re_q, re_d;
  logic                  we_q, we_d;
  logic [TIMEOUT_W-1:0]  wait_q, wait_d;
  logic                  br_taken_q, br_taken_d;
  logic [XLEN-1:0]       br_target_q, br_target_d;
  logic [XLEN-1:0]       ex_addr_q, ex_addr_d;
  logic                  mem_load_q, mem_load_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IF;
      pc_q        <= RESET_VECTOR;
      ir_q        <= '0;
      load_data_q <= '0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      wait_q      <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      ex_addr_q   <= '0;
      mem_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      load_data_q <= load_data_d;
      re_q        <= re_d;
      we_q        <= we_d;
      wait_q      <= wait_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      ex_addr_q   <= ex_addr_d;
      mem_load_q  <= mem_load_d;
    end
  end

  // Halt leaves every next-state equal to current state, so nothing moves while it is high.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    load_data_d = load_data_q;
    re_d        = re_q;
    we_d        = we_q;
    wait_d      = wait_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    ex_addr_d   = ex_addr_q;
    mem_load_d  = mem_load_q;
    if (!i_halt) begin
      case (state_q)
        S_IF: begin
          if (!re_q) begin
            re_d = 1'b1;
          end else if (!mem.mem_busy) begin
            ir_d   = mem.mem_rdata;
            re_d   = 1'b0;
            wait_d = '0;
            state_d = S_ID;
          end
        end
        S_ID: state_d = S_EX;
        S_EX: begin
          br_taken_d  = i_branch_taken;
          br_target_d = i_branch_target;
          ex_addr_d   = i_ex_address;
          mem_load_d  = i_dec_is_load;
          state_d     = (i_dec_is_load || i_dec_is_store) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (!re_q && !we_q) begin
            re_d = mem_load_q;
            we_d = !mem_load_q;
          end else if (!mem.mem_busy) begin
            if (mem_load_q) load_data_d = mem.mem_rdata[XLEN-1:0];
            re_d    = 1'b0;
            we_d    = 1'b0;
            wait_d  = '0;
            state_d = S_WB;
          end
        end
        S_WB: begin
          pc_d    = br_taken_q ? br_target_q : pc_q + PC_INC;
          state_d = S_IF;
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: state_d = S_FAULT;
      endcase
      // A busy cycle that would make the counter saturate aborts the transfer for good.
      if ((re_q || we_q) && mem.mem_busy) begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_LAST) begin
          re_d    = 1'b0;
          we_d    = 1'b0;
          state_d = S_FAULT;
        end
      end
    end
  end

  assign mem.mem_address = (state_q == S_MEM) ? ex_addr_q : pc_q;
  assign mem.mem_re      = re_q && !i_halt;
  assign mem.mem_we      = we_q && !i_halt;

  assign o_pc           = pc_q;
  assign o_instruction  = ir_q;
  assign o_load_data    = load_data_q;
  assign o_stage        = state_q;
  assign o_retire       = (state_q == S_WB) && !i_halt;
  assign o_reg_write_en = o_retire && i_dec_writes_rd;
  assign o_fault        = (state_q == S_FAULT);

`ifdef ARGON_SEQ_PERF_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] retire_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (!i_halt) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (o_retire) retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign o_cycle_count  = cycle_cnt_q;
  assign o_retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_argon_sequencer.sv
// Self-checking bench for argon_sequencer: fetch/ALU, load with wait states, branches and PC wrap,
// store under halt, reset mid-transfer, bus timeout, and optional performance counters.
module tb_argon_sequencer;
  localparam int XLEN = 16;
  localparam int ILEN = 32;
  localparam int W    = XLEN + 1;

  logic            clk;
  logic            i_reset;
  logic            i_halt;
  logic            dec_is_load;
  logic            dec_is_store;
  logic            dec_writes_rd;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] ex_address;
  logic [XLEN-1:0] o_pc;
  logic [ILEN-1:0] o_instruction;
  logic [XLEN-1:0] o_load_data;
  logic [2:0]      o_stage;
  logic            o_reg_write_en;
  logic            o_retire;
  logic            o_fault;
`ifdef ARGON_SEQ_PERF_EN
  logic [31:0]     o_cycle_count;
  logic [31:0]     o_retire_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int retire_seen = 0;
  int wen_seen = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  argon_sequencer_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  argon_sequencer #(
    .XLEN(XLEN), .ILEN(ILEN), .RESET_VECTOR(16'h0100), .PC_STEP(4), .TIMEOUT_W(4)
  ) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_halt(i_halt),
    .mem(bus),
    .i_dec_is_load(dec_is_load),
    .i_dec_is_store(dec_is_store),
    .i_dec_writes_rd(dec_writes_rd),
    .i_branch_taken(branch_taken),
    .i_branch_target(branch_target),
    .i_ex_address(ex_address),
    .o_pc(o_pc),
    .o_instruction(o_instruction),
    .o_load_data(o_load_data),
    .o_stage(o_stage),
    .o_reg_write_en(o_reg_write_en),
    .o_retire(o_retire),
    .o_fault(o_fault)
`ifdef ARGON_SEQ_PERF_EN
    ,
    .o_cycle_count(o_cycle_count),
    .o_retire_count(o_retire_count)
`endif
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Completed transfers and strobes, sampled mid-cycle away from the active edge
  always @(negedge clk) begin
    if (o_retire) retire_seen++;
    if (o_reg_write_en) wen_seen++;
    if (!i_reset && (bus.mem_re || bus.mem_we) && !bus.mem_busy)
      got_q.push_back({bus.mem_we, bus.mem_address});
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic wait_strobe(input int max_cycles, output int n);
    n = 0;
    while (!(bus.mem_re || bus.mem_we) && n < max_cycles) begin
      tick();
      n++;
    end
  endtask

  task automatic set_op(input logic ld, input logic st, input logic wr);
    dec_is_load   = ld;
    dec_is_store  = st;
    dec_writes_rd = wr;
  endtask

  // Tests
  task automatic test_reset();
    i_reset = 1'b1;
    i_halt  = 1'b1;
    repeat (3) tick();
    checks++;
    if (o_pc !== 16'h0100) begin errors++; $display("FAIL reset_pc: got %h, expected 0100", o_pc); end
    checks++;
    if (o_stage !== 3'd0 || o_fault !== 1'b0) begin
      errors++; $display("FAIL reset_stage: stage %0d fault %b, expected 0 0", o_stage, o_fault);
    end
    i_halt = 1'b0;
    #1;
    checks++;
    if ({bus.mem_re, bus.mem_we, o_retire, o_reg_write_en} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: re/we/retire/wen %b, expected 0000",
                         {bus.mem_re, bus.mem_we, o_retire, o_reg_write_en});
    end
    checks++;
    if (o_instruction !== 32'h0 || o_load_data !== 16'h0) begin
      errors++; $display("FAIL reset_regs: ir %h load %h, expected 0 0", o_instruction, o_load_data);
    end
  endtask

  task automatic test_alu(output int c1);
    int n, c0, r0, w0;
    logic [W-1:0] e, g;
    set_op(1'b0, 1'b0, 1'b1);
    bus.mem_busy  = 1'b0;
    bus.mem_rdata = 32'h0000_0013;
    branch_taken  = 1'b0;
    exp_q.push_back({1'b0, 16'h0100});
    r0 = retire_seen;
    w0 = wen_seen;
    i_reset = 1'b0;
    #1;
    checks++;
    if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL alu_cycle0_re: got %b, expected 0", bus.mem_re); end
    wait_strobe(10, n);
    c0 = cyc;
    checks++;
    if (n !== 1 || bus.mem_address !== 16'h0100) begin
      errors++; $display("FAIL alu_first_req: after %0d cycles at %h, expected 1 at 0100", n, bus.mem_address);
    end
    tick();
    checks++;
    if (o_stage !== 3'd1 || o_instruction !== 32'h0000_0013) begin
      errors++; $display("FAIL alu_id: stage %0d ir %h, expected 1 00000013", o_stage, o_instruction);
    end
    tick();
    tick();
    checks++;
    if (o_stage !== 3'd4 || o_retire !== 1'b1 || o_reg_write_en !== 1'b1) begin
      errors++; $display("FAIL alu_wb: stage %0d retire %b wen %b, expected 4 1 1", o_stage, o_retire, o_reg_write_en);
    end
    tick();
    checks++;
    if (o_pc !== 16'h0104) begin errors++; $display("FAIL alu_pc: got %h, expected 0104", o_pc); end
    wait_strobe(10, n);
    c1 = cyc;
    checks++;
    if (c1 - c0 !== 5 || bus.mem_address !== 16'h0104) begin
      errors++; $display("FAIL alu_next_req: %0d cycles at %h, expected 5 at 0104", c1 - c0, bus.mem_address);
    end
    checks++;
    if (retire_seen - r0 !== 1 || wen_seen - w0 !== 1) begin
      errors++; $display("FAIL alu_pulses: retire %0d wen %0d, expected 1 1", retire_seen - r0, wen_seen - w0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
      checks++;
      if (g !== e) begin errors++; $display("FAIL alu_xfer: got %h, expected %h", g, e); end
    end
  endtask

  task automatic test_load(input int c1);
    int start, r0, w0;
    logic [W-1:0] e, g;
    start = c1 - 1;
    set_op(1'b1, 1'b0, 1'b1);
    ex_address    = 16'h2000;
    bus.mem_rdata = 32'h0000_BEEF;
    exp_q.push_back({1'b0, 16'h0104});
    exp_q.push_back({1'b0, 16'h2000});
    r0 = retire_seen;
    w0 = wen_seen;
    tick();
    tick();
    tick();
    checks++;
    if (o_stage !== 3'd3 || bus.mem_re !== 1'b0) begin
      errors++; $display("FAIL load_mem_entry: stage %0d re %b, expected 3 0", o_stage, bus.mem_re);
    end
    bus.mem_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) bus.mem_busy = 1'b0;
      checks++;
      if (bus.mem_re !== 1'b1 || bus.mem_address !== 16'h2000) begin
        errors++; $display("FAIL load_req_hold: cycle %0d re %b addr %h, expected 1 2000", k, bus.mem_re, bus.mem_address);
      end
    end
    tick();
    checks++;
    if (o_stage !== 3'd4 || o_load_data !== 16'hBEEF || cyc - start + 1 !== 10) begin
      errors++; $display("FAIL load_wb: stage %0d data %h latency %0d, expected 4 beef 10",
                         o_stage, o_load_data, cyc - start + 1);
    end
    tick();
    checks++;
    if (o_pc !== 16'h0108 || wen_seen - w0 !== 1 || retire_seen - r0 !== 1) begin
      errors++; $display("FAIL load_done: pc %h wen %0d retire %0d, expected 0108 1 1", o_pc, wen_seen - w0, retire_seen - r0);
    end
    set_op(1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
      checks++;
      if (g !== e) begin errors++; $display("FAIL load_xfer: got %h, expected %h", g, e); end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL load_extra: %0d extra transfers, expected 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_branch();
    int r0, w0;
    logic [W-1:0] e, g;
    logic [XLEN-1:0] pcs [4];
    logic [XLEN-1:0] tgts [4];
    logic [XLEN-1:0] want [4];
    logic            tk [4];
    pcs  = '{16'h0108, 16'hFFFC, 16'h0040, 16'hFFFC};
    tgts = '{16'hFFFC, 16'h0040, 16'hFFFC, 16'h1234};
    tk   = '{1'b1, 1'b1, 1'b1, 1'b0};
    want = '{16'hFFFC, 16'h0040, 16'hFFFC, 16'h0000};
    set_op(1'b0, 1'b0, 1'b0);
    r0 = retire_seen;
    w0 = wen_seen;
    for (int i = 0; i < 4; i++) begin
      branch_taken  = tk[i];
      branch_target = tgts[i];
      exp_q.push_back({1'b0, pcs[i]});
      repeat (5) tick();
      checks++;
      if (o_pc !== want[i]) begin errors++; $display("FAIL branch_pc%0d: got %h, expected %h", i, o_pc, want[i]); end
    end
    branch_taken = 1'b0;
    checks++;
    if (retire_seen - r0 !== 4 || wen_seen - w0 !== 0) begin
      errors++; $display("FAIL branch_pulses: retire %0d wen %0d, expected 4 0", retire_seen - r0, wen_seen - w0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
      checks++;
      if (g !== e) begin errors++; $display("FAIL branch_xfer: got %h, expected %h", g, e); end
    end
  endtask

  task automatic test_store_halt();
    int r0;
    logic [W-1:0] e, g;
    set_op(1'b0, 1'b1, 1'b0);
    ex_address = 16'h3000;
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b1, 16'h3000});
    r0 = retire_seen;
    repeat (4) tick();
    checks++;
    if (o_stage !== 3'd3 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL store_mem_entry: stage %0d we %b, expected 3 0", o_stage, bus.mem_we);
    end
    tick();
    i_halt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      #1;
      checks++;
      if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0 || o_stage !== 3'd3) begin
        errors++; $display("FAIL store_halted: cycle %0d we %b re %b stage %0d, expected 0 0 3", k, bus.mem_we, bus.mem_re, o_stage);
      end
    end
    tick();
    i_halt = 1'b0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_address !== 16'h3000) begin
      errors++; $display("FAIL store_reissue: we %b addr %h, expected 1 3000", bus.mem_we, bus.mem_address);
    end
    tick();
    checks++;
    if (o_retire !== 1'b1) begin errors++; $display("FAIL store_wb: retire %b, expected 1", o_retire); end
    tick();
    checks++;
    if (o_pc !== 16'h0004 || retire_seen - r0 !== 1) begin
      errors++; $display("FAIL store_done: pc %h retire %0d, expected 0004 1", o_pc, retire_seen - r0);
    end
    set_op(1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
      checks++;
      if (g !== e) begin errors++; $display("FAIL store_xfer: got %h, expected %h", g, e); end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL store_extra: %0d extra transfers, expected 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_reset_mid();
    bus.mem_busy = 1'b1;
    repeat (3) tick();
    i_reset = 1'b1;
    tick();
    checks++;
    if (bus.mem_re !== 1'b0 || o_stage !== 3'd0 || o_pc !== 16'h0100) begin
      errors++; $display("FAIL resetmid_drop: re %b stage %0d pc %h, expected 0 0 0100", bus.mem_re, o_stage, o_pc);
    end
    bus.mem_busy = 1'b0;
    tick();
    i_reset = 1'b0;
    #1;
    checks++;
    if (got_q.size() != 0 || bus.mem_re !== 1'b0) begin
      errors++; $display("FAIL resetmid_late: %0d transfers re %b, expected 0 0", got_q.size(), bus.mem_re);
      got_q.delete();
    end
  endtask

  task automatic test_timeout();
    int n, r0;
    logic [W-1:0] e, g;
    r0 = retire_seen;
    bus.mem_busy = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_fault) break;
      if (bus.mem_re) n++;
    end
    checks++;
    if (n !== 15 || o_fault !== 1'b1) begin
      errors++; $display("FAIL timeout_busy: %0d busy cycles fault %b, expected 15 1", n, o_fault);
    end
    checks++;
    if (o_stage !== 3'd7 || bus.mem_re !== 1'b0) begin
      errors++; $display("FAIL timeout_state: stage %0d re %b, expected 7 0", o_stage, bus.mem_re);
    end
    bus.mem_busy = 1'b0;
    repeat (6) tick();
    checks++;
    if (o_fault !== 1'b1 || o_stage !== 3'd7 || bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || retire_seen != r0) begin
      errors++; $display("FAIL timeout_sticky: fault %b stage %0d re %b we %b retires %0d, expected 1 7 0 0 0",
                         o_fault, o_stage, bus.mem_re, bus.mem_we, retire_seen - r0);
    end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_fault !== 1'b0 || o_stage !== 3'd0 || o_pc !== 16'h0100) begin
      errors++; $display("FAIL timeout_recover: fault %b stage %0d pc %h, expected 0 0 0100", o_fault, o_stage, o_pc);
    end
    exp_q.push_back({1'b0, 16'h0100});
    wait_strobe(5, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL timeout_refetch: %0d cycles, expected 1", n); end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
      checks++;
      if (g !== e) begin errors++; $display("FAIL timeout_xfer: got %h, expected %h", g, e); end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL timeout_extra: %0d extra transfers, expected 0", got_q.size()); got_q.delete(); end
  endtask

`ifdef ARGON_SEQ_PERF_EN
  task automatic test_perf();
    logic [W-1:0] e, g;
    i_reset = 1'b1;
    tick();
    set_op(1'b0, 1'b0, 1'b1);
    branch_taken = 1'b0;
    bus.mem_busy = 1'b0;
    checks++;
    if (o_cycle_count !== 32'd0 || o_retire_count !== 32'd0) begin
      errors++; $display("FAIL perf_reset: cycles %0d retires %0d, expected 0 0", o_cycle_count, o_retire_count);
    end
    got_q.delete();
    exp_q.push_back({1'b0, 16'h0100});
    exp_q.push_back({1'b0, 16'h0104});
    exp_q.push_back({1'b0, 16'h0108});
    i_reset = 1'b0;
    repeat (15) tick();
    checks++;
    if (o_cycle_count !== 32'd15 || o_retire_count !== 32'd3) begin
      errors++; $display("FAIL perf_counts: cycles %0d retires %0d, expected 15 3", o_cycle_count, o_retire_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
      checks++;
      if (g !== e) begin errors++; $display("FAIL perf_xfer: got %h, expected %h", g, e); end
    end
  endtask
`endif

  initial begin
    int c1;
    i_reset       = 1'b1;
    i_halt        = 1'b0;
    dec_is_load   = 1'b0;
    dec_is_store  = 1'b0;
    dec_writes_rd = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    ex_address    = '0;
    bus.mem_busy  = 1'b0;
    bus.mem_rdata = '0;

    test_reset();
    test_alu(c1);
    test_load(c1);
    test_branch();
    test_store_halt();
    test_reset_mid();
    test_timeout();
`ifdef ARGON_SEQ_PERF_EN
    test_perf();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
